// File: rtl/board_row_renderer.sv
// board_row_renderer: draws a BOARD_COLS x BOARD_ROWS cell board into the VGA pixel stream.
// Each board row is fetched from the board store over a req/ack handshake into a
// ping-pong row buffer. The front buffer is displayed while the back buffer is filled,
// and the two swap at the top of the next cell row. The pixel output is registered.
// Optional macro BOARD_GRID_EN: empty cells draw a 0x202020 grid line on their
// left/top pixel, and the board's right/bottom border lines use the same colour.
module board_row_renderer #(
    parameter int unsigned CELL_SIZE   = 21,
    parameter int unsigned BOARD_COLS  = 10,
    parameter int unsigned BOARD_ROWS  = 20,
    parameter int unsigned LEFT_EDGE   = 213,
    parameter int unsigned CELL_W      = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter logic [23:0] BG_RGB      = 24'h00FC39
) (
    input  logic                         Clk,
    input  logic                         reset_n,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   DrawY,
    input  logic                         hs,
    output logic                         row_req,
    output logic [7:0]                   row_num,
    input  logic                         row_ack,
    input  logic [BOARD_COLS*CELL_W-1:0] row_data,
    output logic [7:0]                   Red,
    output logic [7:0]                   Green,
    output logic [7:0]                   Blue,
    output logic                         row_miss
);

    // Only the RGB444 part of each cell word is stored; the tag bits are never shown.
    localparam int unsigned ROW_W     = BOARD_COLS * CELL_W;
    localparam int unsigned BUF_W     = BOARD_COLS * 12;
    localparam int unsigned CNT_W     = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [10:0] LEFT      = 11'(LEFT_EDGE);
    localparam logic [10:0] RIGHT     = 11'(LEFT_EDGE + BOARD_COLS * CELL_SIZE);
    localparam logic [10:0] BOTTOM    = 11'(BOARD_ROWS * CELL_SIZE);
    localparam logic [10:0] CS        = 11'(CELL_SIZE);
    localparam logic [10:0] CS_LAST   = 11'(CELL_SIZE - 1);
    localparam logic [10:0] LAST_LINE = 11'd479;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
`ifdef BOARD_GRID_EN
    localparam logic [23:0] GRID_RGB  = 24'h202020;
`endif

    typedef enum logic [1:0] {StIdle, StReq, StReady} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       row_num_q, row_num_d;
    logic             front_q, front_d;
    logic             miss_q, miss_d;
    logic             hs_q;
    logic             capture;
    logic [BUF_W-1:0] row_q [2];
    logic [BUF_W-1:0] row_rgb_in;
    logic [23:0]      rgb_q, rgb_d;

    logic [10:0] x11, y11, dx, col, px, py, target;
    logic        board_on, on_outline, trigger;
    logic [11:0] cell_rgb;
    logic        unused_tag;
`ifdef BOARD_GRID_EN
    logic        on_border;
`endif

    // Pixel geometry, all at 11 bits so LEFT_EDGE + board width cannot overflow.
    always_comb begin
        x11      = {1'b0, DrawX};
        y11      = {1'b0, DrawY};
        dx       = x11 - LEFT;
        col      = dx / CS;
        px       = dx % CS;
        py       = y11 % CS;
        board_on = (x11 >= LEFT) && (x11 < RIGHT) && (y11 < BOTTOM);
        on_outline = (px == 11'd0) || (px == CS_LAST) || (py == 11'd0) || (py == CS_LAST);
`ifdef BOARD_GRID_EN
        on_border = ((x11 == RIGHT) && (y11 <= BOTTOM)) ||
                    ((y11 == BOTTOM) && (x11 >= LEFT) && (x11 <= RIGHT));
`endif
    end

    // Select the displayed cell from the front buffer; out-of-range columns read as empty.
    always_comb begin
        cell_rgb = '0;
        for (int c = 0; c < BOARD_COLS; c++) begin
            if (col == 11'(c)) begin
                cell_rgb = row_q[front_q][c*12 +: 12];
            end
        end
    end

    // Strip the tag bits from the incoming row.
    always_comb begin
        row_rgb_in = '0;
        unused_tag = 1'b0;
        for (int c = 0; c < BOARD_COLS; c++) begin
            row_rgb_in[c*12 +: 12] = row_data[c*CELL_W +: 12];
        end
        for (int b = 0; b < ROW_W; b++) begin
            if ((b % CELL_W) >= 12) begin
                unused_tag = unused_tag ^ row_data[b];
            end
        end
    end

    // Next pixel colour: background, cell outline, cell fill or empty cell.
    always_comb begin
        rgb_d = BG_RGB;
        if (board_on) begin
            if (cell_rgb != 12'h000) begin
                if (on_outline) begin
                    rgb_d = 24'h000000;
                end else begin
                    rgb_d = {cell_rgb[11:8], 4'h0, cell_rgb[7:4], 4'h0, cell_rgb[3:0], 4'h0};
                end
            end else begin
`ifdef BOARD_GRID_EN
                rgb_d = ((px == 11'd0) || (py == 11'd0)) ? GRID_RGB : 24'h000000;
`else
                rgb_d = 24'h000000;
`endif
            end
        end
`ifdef BOARD_GRID_EN
        else if (on_border) begin
            rgb_d = GRID_RGB;
        end
`endif
    end

    // Fetch trigger on the hs rising edge of a cell row's last line, or the frame's last line.
    always_comb begin
        trigger = hs && !hs_q && ((py == CS_LAST) || (y11 >= LAST_LINE));
        target  = (y11 + 11'd1) / CS;
        if ((target >= 11'(BOARD_ROWS)) || (y11 >= LAST_LINE)) begin
            target = 11'd0;
        end
    end

    // Fetch FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_num_d = row_num_q;
        front_d   = front_q;
        miss_d    = miss_q;
        capture   = 1'b0;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d   = StReq;
                    row_num_d = target[7:0];
                    cnt_d     = '0;
                end
            end
            StReq: begin
                // An ack on the terminal count still wins over the timeout.
                if (row_ack) begin
                    capture = 1'b1;
                    state_d = StReady;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                    miss_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                if ((py == 11'd0) && (x11 == 11'd0)) begin
                    front_d = ~front_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        row_req  = (state_q == StReq);
        row_num  = row_num_q;
        row_miss = miss_q;
        Red      = rgb_q[23:16];
        Green    = rgb_q[15:8];
        Blue     = rgb_q[7:0];
    end

    // State, handshake, row buffers and pixel output registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            row_num_q <= '0;
            front_q   <= 1'b0;
            miss_q    <= 1'b0;
            hs_q      <= 1'b0;
            rgb_q     <= '0;
            row_q[0]  <= '0;
            row_q[1]  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_num_q <= row_num_d;
            front_q   <= front_d;
            miss_q    <= miss_d;
            hs_q      <= hs;
            rgb_q     <= rgb_d;
            for (int i = 0; i < 2; i++) begin
                if (capture && (front_q != 1'(i))) begin
                    row_q[i] <= row_rgb_in;
                end
            end
        end
    end

endmodule
